// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl
// Head/tail pointer controller for the reorder buffer. Rename/dispatch
// allocates up to ALLOC_W entries per cycle at the tail. Commit retires up
// to RETIRE_W entries per cycle at the head. A mispredict flush rewinds the
// tail to a younger-than-head position.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   reset_n_i      synchronous active-low reset
//   alloc_cnt_i    entries requested this cycle (0..ALLOC_W)
//   retire_cnt_i   entries committed this cycle (0..RETIRE_W)
//   flush_i        mispredict flush; tail is rewound to flush_tail_i
//   flush_tail_i   new tail, including the wrap bit
//   alloc_grant_o  allocation accepted this cycle (combinational)
//   stall_o        non-zero request that was not granted (combinational)
//   alloc_idx_o    slot k = (tail+k) mod ROB_SIZE; slot 0 is in the LSBs
//   head_o         index of the oldest entry
//   tail_o         index of the next free entry
//   count_o        number of occupied entries, 0..ROB_SIZE
//   empty_o        count_o == 0
//   full_o         count_o == ROB_SIZE
//   err_o          sticky protocol error; cleared only by reset
module rob_ptr_ctrl #(
    parameter  int ROB_SIZE = 32,
    parameter  int ALLOC_W  = 2,
    parameter  int RETIRE_W = 2,
    localparam int ADDR_W   = $clog2(ROB_SIZE),
    localparam int AC_W     = $clog2(ALLOC_W + 1),
    localparam int RC_W     = $clog2(RETIRE_W + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [AC_W-1:0]           alloc_cnt_i,
    input  logic [RC_W-1:0]           retire_cnt_i,
    input  logic                      flush_i,
    input  logic [ADDR_W:0]           flush_tail_i,
    output logic                      alloc_grant_o,
    output logic                      stall_o,
    output logic [ALLOC_W*ADDR_W-1:0] alloc_idx_o,
    output logic [ADDR_W-1:0]         head_o,
    output logic [ADDR_W-1:0]         tail_o,
    output logic [ADDR_W:0]           count_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      err_o
);

    localparam int PW = ADDR_W + 1;

    // Pointers carry one extra wrap bit, so tail-head in PW bits gives an
    // unambiguous occupancy of 0..ROB_SIZE.
    logic [PW-1:0] head_q, tail_q;
    logic          err_q;

    logic [PW-1:0] count, free;
    logic [PW-1:0] alloc_ext, retire_ext, retire_amt;
    logic [PW-1:0] head_nxt, tail_nxt;
    logic          retire_ovf, flush_ok, err_nxt;

    assign count      = tail_q - head_q;
    assign free       = PW'(ROB_SIZE) - count;
    assign alloc_ext  = PW'(alloc_cnt_i);
    assign retire_ext = PW'(retire_cnt_i);

    // Free space comes from registered state only; a same-cycle retire
    // does not give credit to the allocation.
    assign alloc_grant_o = !flush_i && (alloc_ext <= free);
    assign stall_o       = (alloc_cnt_i != '0) && !alloc_grant_o;

    // Retiring more than is occupied is clamped and flagged.
    assign retire_ovf = retire_ext > count;
    assign retire_amt = retire_ovf ? count : retire_ext;
    assign head_nxt   = head_q + retire_amt;

    // The flush target is measured from the post-retire head, so a valid
    // target can never put the tail behind the head that retire produces.
    // Modular distances handle every wrap case.
    assign flush_ok = (flush_tail_i - head_nxt) <= (tail_q - head_nxt);

    always_comb begin
        tail_nxt = tail_q;
        if (flush_i) begin
            if (flush_ok) tail_nxt = flush_tail_i;
        end else if (alloc_grant_o) begin
            tail_nxt = tail_q + alloc_ext;
        end
    end

    assign err_nxt = err_q | retire_ovf | (flush_i & !flush_ok);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            head_q <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_nxt;
            tail_q <= tail_nxt;
            err_q  <= err_nxt;
        end
    end

    // Each slot index wraps on its own, independent of the other slots.
    for (genvar k = 0; k < ALLOC_W; k++) begin : g_slot
        assign alloc_idx_o[k*ADDR_W +: ADDR_W] = tail_q[ADDR_W-1:0] + ADDR_W'(k);
    end

    assign head_o  = head_q[ADDR_W-1:0];
    assign tail_o  = tail_q[ADDR_W-1:0];
    assign count_o = count;
    assign empty_o = (count == '0);
    assign full_o  = (count == PW'(ROB_SIZE));
    assign err_o   = err_q;

endmodule
